// File: rtl/hs_angle_scheduler_pkg.sv
// Shared types and constants for the back-projection angle scheduler.
// Holds the FSM state encoding and the shared angle bus/step constants.
// No logic; imported by the scheduler and its arbiter.
`ifndef kAngleLength
`define kAngleLength 16
`endif
`ifndef kAngleStep
`define kAngleStep 45
`endif

package hs_angle_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_ADVANCE  = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam int ANGLE_WIDTH_DEFAULT = `kAngleLength;

  // Pointer width that stays legal for a single-entry unit array.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hs_angle_scheduler_rr_arbiter.sv
// Round-robin priority select: first eligible index at or above ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; any=0 when nothing is eligible.
module hs_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  localparam logic [PTR_W:0] NU = (PTR_W+1)'(N);

  logic [PTR_W:0] pos;

  // Walk the ring starting at ptr and latch the first eligible entry.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= NU) pos = pos - NU;
      if (!any && eligible[pos[PTR_W-1:0]]) begin
        any                 = 1'b1;
        grant[pos[PTR_W-1:0]] = 1'b1;
        index               = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hs_angle_scheduler.sv
// Back-projection pass sequencer: fetches angles and dispatches them round-robin to units.
// Latency: 3 cycles per angle minimum (fetch, dispatch, advance); all outputs registered.
// Backpressure: stalls in dispatch while no unit is ready and idle; holds the advance until ack.
module hs_angle_scheduler
  import hs_angle_scheduler_pkg::*;
#(
  parameter int ANGLE_WIDTH = `kAngleLength,
  parameter int NUM_UNITS   = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] angle_count,
  input  logic [ANGLE_WIDTH-1:0] hs_angle,
  input  logic                   hs_has_next_angle,
  output logic                   hs_next_angle,
  input  logic                   hs_next_angle_ack,
  input  logic [NUM_UNITS-1:0]   unit_ready,
  input  logic [NUM_UNITS-1:0]   unit_done,
  output logic [NUM_UNITS-1:0]   unit_valid,
  output logic [ANGLE_WIDTH-1:0] unit_angle
);

  localparam int PTR_W = ptr_width(NUM_UNITS);

  state_t                 state_q, state_d;
  logic [NUM_UNITS-1:0]   busy_mask_q, busy_mask_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_UNITS-1:0]   eligible, grant, valid_d;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_any, grant_en;
  logic                   busy_d, done_d, next_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [ANGLE_WIDTH-1:0] angle_d;

  assign eligible = unit_ready & ~busy_mask_q;
  assign grant_en = (state_q == ST_DISPATCH) && grant_any;

  hs_rr_arbiter #(
    .N     (NUM_UNITS),
    .PTR_W (PTR_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .index    (grant_idx),
    .any      (grant_any)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_DISPATCH;
      ST_DISPATCH: if (grant_any) state_d = ST_ADVANCE;
      ST_ADVANCE: begin
        if (!hs_has_next_angle)                     state_d = ST_DRAIN;
        else if (hs_next_angle && hs_next_angle_ack) state_d = ST_FETCH;
      end
      ST_DRAIN:    if (busy_mask_q == '0) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and tracking state, derived from state_d.
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    // Advance request is raised on entry to ADVANCE and held until the source acks.
    next_d      = (state_d == ST_ADVANCE) && hs_has_next_angle;
    valid_d     = grant_en ? grant : '0;
    angle_d     = grant_en ? hs_angle : unit_angle;
    busy_mask_d = (busy_mask_q & ~unit_done) | (grant_en ? grant : '0);
    rr_ptr_d    = rr_ptr_q;
    if (grant_en)
      rr_ptr_d = (grant_idx == PTR_W'(NUM_UNITS-1)) ? '0 : grant_idx + 1'b1;
    count_d     = angle_count;
    if (state_q == ST_IDLE && start)
      count_d = '0;
    else if (grant_en && angle_count != '1)
      count_d = angle_count + 1'b1;
  end

  // Output and tracking registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      hs_next_angle <= 1'b0;
      unit_valid    <= '0;
      unit_angle    <= '0;
      angle_count   <= '0;
      busy_mask_q   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      busy          <= busy_d;
      done          <= done_d;
      hs_next_angle <= next_d;
      unit_valid    <= valid_d;
      unit_angle    <= angle_d;
      angle_count   <= count_d;
      busy_mask_q   <= busy_mask_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_hs_angle_scheduler.sv
// Directed bench for hs_angle_scheduler with a dispatch scoreboard.
// Source and unit models react to the DUT; expected strobes are queued per pass.
// Each pass is bounded by a cycle budget so the run always terminates.
module tb_hs_angle_scheduler;

  localparam int AW = 16;
  localparam int NU = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, hs_next_angle, hs_has_next_angle, hs_next_angle_ack;
  logic [CW-1:0] angle_count;
  logic [AW-1:0] hs_angle, unit_angle;
  logic [NU-1:0] unit_ready = '0;
  logic [NU-1:0] unit_done, unit_valid;

  // Bench-side model controls.
  int            n_angles = 4;
  int            idx;
  logic          src_rewind = 1'b1;
  logic          ack_hold = 1'b0;
  int            done_delay = 1;
  logic [NU-1:0] release_mask = '0;
  logic [NU-1:0] spur_done = '0;
  logic [NU-1:0] model_done, pending;
  int            cnt [NU];

  typedef struct { int unit; int angle; } exp_t;
  exp_t exp_q [$];

  int errors = 0;
  int checks = 0;
  int n_strobe, done_seen, adv_seen;

  hs_angle_scheduler #(.ANGLE_WIDTH(AW), .NUM_UNITS(NU), .COUNT_WIDTH(CW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .angle_count       (angle_count),
    .hs_angle          (hs_angle),
    .hs_has_next_angle (hs_has_next_angle),
    .hs_next_angle     (hs_next_angle),
    .hs_next_angle_ack (hs_next_angle_ack),
    .unit_ready        (unit_ready),
    .unit_done         (unit_done),
    .unit_valid        (unit_valid),
    .unit_angle        (unit_angle)
  );

  always #5 clk = ~clk;

  // Angle source: angle idx*step, acks any advance unless held off.
  assign hs_angle          = AW'(idx * `kAngleStep);
  assign hs_has_next_angle = (idx < n_angles - 1);
  assign hs_next_angle_ack = hs_next_angle & ~ack_hold;

  always @(posedge clk) begin
    if (src_rewind) idx <= 0;
    else if (hs_next_angle && hs_next_angle_ack && idx < n_angles - 1) idx <= idx + 1;
  end

  // Units: done after done_delay cycles, or held until released when done_delay is 0.
  assign unit_done = model_done | spur_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_done <= '0;
      pending    <= '0;
      for (int i = 0; i < NU; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NU; i++) begin
        model_done[i] <= 1'b0;
        if (unit_valid[i]) begin
          if (done_delay == 0)      pending[i] <= 1'b1;
          else if (done_delay == 1) model_done[i] <= 1'b1;
          else                      cnt[i] <= done_delay - 1;
        end else if (cnt[i] > 0) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1) model_done[i] <= 1'b1;
        end else if (pending[i] && release_mask[i]) begin
          pending[i]    <= 1'b0;
          model_done[i] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int unit, input int angle);
    exp_t e;
    e.unit  = unit;
    e.angle = angle;
    exp_q.push_back(e);
  endtask

  // One cycle; sample at the falling edge and score any dispatch strobe.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (unit_valid != '0) begin
      n_strobe++;
      if (exp_q.size() == 0) chk("unexpected_strobe", 32'(unit_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("strobe_unit", 32'(unit_valid), 32'(1) << e.unit);
        chk("strobe_angle", 32'(unit_angle), 32'(e.angle));
      end
    end
    if (done) done_seen++;
    if (hs_next_angle && hs_next_angle_ack) adv_seen++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; src_rewind = 1'b1; start = 1'b0; ack_hold = 1'b0;
    release_mask = '0; spur_done = '0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    n_strobe = 0; done_seen = 0; adv_seen = 0;
    reset_n = 1'b1; src_rewind = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (n_strobe < target && n < budget) begin tick(); n++; end
    chk("strobe_count", 32'(n_strobe), 32'(target));
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    int d0 = done_seen;
    while (done_seen == d0 && n < budget) begin tick(); n++; end
    chk("done_reached", 32'(done_seen - d0), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit ok_valid, ok_next, ok_busy;
    int n;

    // Reset state.
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_next", 32'(hs_next_angle), 32'd0);
    chk("rst_valid", 32'(unit_valid), 32'd0);
    chk("rst_angle", 32'(unit_angle), 32'd0);
    chk("rst_count", 32'(angle_count), 32'd0);

    // Single unit, done 5 cycles after each strobe.
    unit_ready = 4'b0001; done_delay = 5; n_angles = 4;
    for (int i = 0; i < 4; i++) push(0, i * `kAngleStep);
    pulse_start();
    run_to_done(300);
    chk("t1_count", 32'(angle_count), 32'd4);
    chk("t1_advances", 32'(adv_seen), 32'd3);
    chk("t1_done_pulses", 32'(done_seen), 32'd1);

    // Four units, completions held until the end; first advance ack delayed.
    do_reset();
    unit_ready = 4'b1111; done_delay = 0; n_angles = 4; ack_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(i, i * `kAngleStep);
    pulse_start();
    n = 0;
    while (!hs_next_angle && n < 20) begin tick(); n++; end
    repeat (3) tick();
    chk("t2_next_held", 32'(hs_next_angle), 32'd1);
    chk("t2_no_adv_while_held", 32'(adv_seen), 32'd0);
    chk("t2_one_strobe_while_held", 32'(n_strobe), 32'd1);
    ack_hold = 1'b0;
    wait_strobes(4, 60);
    repeat (10) tick();
    chk("t2_drain_holds_busy", 32'(busy), 32'd1);
    release_mask = 4'b0111;
    repeat (5) tick();
    chk("t2_drain_partial_busy", 32'(busy), 32'd1);
    chk("t2_no_early_done", 32'(done_seen), 32'd0);
    release_mask = 4'b1111;
    run_to_done(40);
    chk("t2_count", 32'(angle_count), 32'd4);

    // Stall: no unit ready for 20 cycles, then unit 1 becomes ready.
    do_reset();
    unit_ready = 4'b0000; done_delay = 1; n_angles = 2;
    push(1, 0); push(1, `kAngleStep);
    pulse_start();
    ok_valid = 1; ok_next = 1; ok_busy = 1;
    repeat (20) begin
      tick();
      if (unit_valid != '0) ok_valid = 0;
      if (hs_next_angle)    ok_next  = 0;
      if (!busy)            ok_busy  = 0;
    end
    chk("t3_stall_no_valid", 32'(ok_valid), 32'd1);
    chk("t3_stall_no_next", 32'(ok_next), 32'd1);
    chk("t3_stall_busy", 32'(ok_busy), 32'd1);
    unit_ready = 4'b0010;
    tick();
    chk("t3_dispatch_after_ready", 32'(unit_valid), 32'b0010);
    run_to_done(100);
    chk("t3_count", 32'(angle_count), 32'd2);

    // Fairness across two ready units that complete immediately.
    do_reset();
    unit_ready = 4'b0011; done_delay = 1; n_angles = 6;
    for (int i = 0; i < 6; i++) push(i % 2, i * `kAngleStep);
    pulse_start();
    run_to_done(200);
    chk("t4_count", 32'(angle_count), 32'd6);

    // Async reset while stalled in dispatch with a unit marked busy.
    do_reset();
    unit_ready = 4'b0001; done_delay = 0; n_angles = 4;
    push(0, 0);
    pulse_start();
    wait_strobes(1, 20);
    repeat (4) tick();
    chk("t5_pre_count", 32'(angle_count), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_next", 32'(hs_next_angle), 32'd0);
    chk("t5_rst_valid", 32'(unit_valid), 32'd0);
    chk("t5_rst_count", 32'(angle_count), 32'd0);
    do_reset();
    chk("t5_no_done_on_abort", 32'(done_seen), 32'd0);
    done_delay = 5;
    for (int i = 0; i < 4; i++) push(0, i * `kAngleStep);
    pulse_start();
    run_to_done(300);
    chk("t5_count", 32'(angle_count), 32'd4);

    // Start while busy and a spurious completion on an idle unit.
    do_reset();
    unit_ready = 4'b1111; done_delay = 3; n_angles = 4;
    for (int i = 0; i < 4; i++) push(i, i * `kAngleStep);
    pulse_start();
    repeat (2) tick();
    start = 1'b1; spur_done = 4'b1000;
    tick();
    start = 1'b0; spur_done = 4'b0000;
    run_to_done(200);
    chk("t6_count", 32'(angle_count), 32'd4);
    chk("t6_done_pulses", 32'(done_seen), 32'd1);
    repeat (5) tick();
    chk("t6_stays_idle", 32'(busy), 32'd0);
    chk("t6_count_holds", 32'(angle_count), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
